encrypt_sched: RTL and testbench

ENCRYPT_SCHED -- requirements
Module: encrypt_sched

---
 rtl/encrypt_sched_pkg.sv | 20 ++
 rtl/encrypt_sched_rr_arb2.sv | 18 +
 rtl/encrypt_sched.sv | 110 +++++++++++
 tb/tb_encrypt_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encrypt_sched_pkg.sv
// Shared types and sizing for the encrypt scheduler.
`define N_B 64
`define N_K 64
`define N_R 10
`define TMO (`N_R + 8)

package encrypt_sched_pkg;
  localparam int NB    = `N_B;
  localparam int NK    = `N_K;
  localparam int NR    = `N_R;
  localparam int TMO   = `TMO;
  localparam int CNT_W = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    REL  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/encrypt_sched_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to pri.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic pri,
  output logic gnt_vld,
  output logic gnt_id
);
  always_comb begin
    gnt_vld = req0 | req1;
    gnt_id  = 1'b0;
    if (req0 && req1) begin
      gnt_id = pri;
    end else if (req1) begin
      gnt_id = 1'b1;
    end
  end
endmodule

// File: rtl/encrypt_sched.sv
// Time-multiplexes one iterative encrypt core between two four-phase requesters.
module encrypt_sched
  import encrypt_sched_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [NB-1:0] m0,
  input  logic [NB-1:0] m1,
  input  logic [NK-1:0] k0,
  input  logic [NK-1:0] k1,
  output logic          ack0,
  output logic          ack1,
  output logic [NB-1:0] c0,
  output logic [NB-1:0] c1,
  output logic          core_req,
  output logic [NB-1:0] core_m,
  output logic [NK-1:0] core_k,
  input  logic          core_ack,
  input  logic [NB-1:0] core_c,
  output logic          busy,
  output logic          err
);
  state_t             state_reg, state_next;
  logic               pri_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [NB-1:0]      m_reg;
  logic [NK-1:0]      k_reg;
  logic               id_reg;
  logic [NB-1:0]      c0_reg, c1_reg;
  logic               err_reg;
  logic               gnt_vld, gnt_id;
  logic               timeout;
  logic               req_sel;

  rr_arb2 u_arb (
    .req0   (req0),
    .req1   (req1),
    .pri    (pri_reg),
    .gnt_vld(gnt_vld),
    .gnt_id (gnt_id)
  );

  assign timeout = (cnt_reg == CNT_W'(TMO - 1));
  assign req_sel = id_reg ? req1 : req0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (gnt_vld) state_next = RUN;
      RUN:  if (core_ack || timeout) state_next = REL;
      REL:  if (!core_ack) state_next = DONE;
      DONE: if (!req_sel) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pri_reg   <= 1'b0;
      cnt_reg   <= '0;
      m_reg     <= '0;
      k_reg     <= '0;
      id_reg    <= 1'b0;
      c0_reg    <= '0;
      c1_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (gnt_vld) begin
            id_reg <= gnt_id;
            m_reg  <= gnt_id ? m1 : m0;
            k_reg  <= gnt_id ? k1 : k0;
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg + 1'b1;
          // A late ack on the final cycle still counts as a good result.
          if (core_ack) begin
            if (id_reg) c1_reg <= core_c;
            else        c0_reg <= core_c;
          end else if (timeout) begin
            err_reg <= 1'b1;
            if (id_reg) c1_reg <= '0;
            else        c0_reg <= '0;
          end
        end
        DONE: begin
          if (!req_sel) pri_reg <= ~id_reg;
        end
        default: ;
      endcase
    end
  end

  assign core_req = (state_reg == RUN);
  assign core_m   = m_reg;
  assign core_k   = k_reg;
  assign busy     = (state_reg != IDLE);
  assign ack0     = (state_reg == DONE) && !id_reg;
  assign ack1     = (state_reg == DONE) && id_reg;
  assign c0       = c0_reg;
  assign c1       = c1_reg;
  assign err      = err_reg;
endmodule

// File: tb/tb_encrypt_sched.sv
// Scoreboard bench for encrypt_sched with a behavioural iterative core.
module tb_encrypt_sched;
  import encrypt_sched_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [NB-1:0] m0 = '0, m1 = '0;
  logic [NK-1:0] k0 = '0, k1 = '0;
  logic          ack0, ack1;
  logic [NB-1:0] c0, c1;
  logic          core_req;
  logic [NB-1:0] core_m;
  logic [NK-1:0] core_k;
  logic          core_ack = 1'b0;
  logic [NB-1:0] core_c = '0;
  logic          busy, err;

  logic          core_hang = 1'b0;
  int            ccnt = 0;
  int            n_vec = 0;
  int            n_miss = 0;

  typedef struct {
    int            port;
    logic [NB-1:0] c;
  } exp_t;
  exp_t sb[$];

  localparam logic [NB-1:0] A5PAT = {(NB/8){8'hA5}};

  encrypt_sched dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .m0(m0), .m1(m1), .k0(k0), .k1(k1),
    .ack0(ack0), .ack1(ack1), .c0(c0), .c1(c1),
    .core_req(core_req), .core_m(core_m), .core_k(core_k),
    .core_ack(core_ack), .core_c(core_c),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [NB-1:0] enc(input logic [NB-1:0] m, input logic [NK-1:0] k);
    return m ^ NB'(k) ^ A5PAT ^ NB'(3);
  endfunction

  function automatic logic [NB-1:0] rnd();
    logic [NB-1:0] v;
    v = {$urandom(), $urandom()};
    return v;
  endfunction

  // Core answers NR cycles after core_req rises, with a one-cycle ack pulse.
  always @(posedge clk) begin
    if (rst) begin
      core_ack <= 1'b0;
      core_c   <= '0;
      ccnt     <= 0;
    end else if (core_ack) begin
      core_ack <= 1'b0;
      ccnt     <= 0;
    end else if (core_req && !core_hang) begin
      if (ccnt == NR - 1) begin
        core_ack <= 1'b1;
        core_c   <= enc(core_m, core_k);
        ccnt     <= 0;
      end else begin
        ccnt <= ccnt + 1;
      end
    end else if (!core_req) begin
      ccnt <= 0;
    end
  end

  task automatic wait_ack(input int budget, output int port, output int cycles);
    port = -1;
    cycles = 0;
    while (cycles < budget && port < 0) begin
      @(negedge clk);
      cycles++;
      if (ack0) port = 0;
      else if (ack1) port = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (core_req !== 1'b0) begin n_miss++; $display("FAIL reset_core_req: got %b want 0", core_req); end
    n_vec++; if (ack0 !== 1'b0) begin n_miss++; $display("FAIL reset_ack0: got %b want 0", ack0); end
    n_vec++; if (ack1 !== 1'b0) begin n_miss++; $display("FAIL reset_ack1: got %b want 0", ack1); end
    n_vec++; if (c0 !== '0) begin n_miss++; $display("FAIL reset_c0: got %h want 0", c0); end
    n_vec++; if (c1 !== '0) begin n_miss++; $display("FAIL reset_c1: got %h want 0", c1); end
    n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL reset_err: got %b want 0", err); end
    n_vec++; if (core_m !== '0) begin n_miss++; $display("FAIL reset_core_m: got %h want 0", core_m); end
    rst = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_single();
    exp_t e;
    int   port, cyc;
    @(negedge clk);
    m0 = NB'(1);
    k0 = NK'(2);
    req0 = 1'b1;
    sb.push_back('{0, A5PAT});
    wait_ack(TMO + 8, port, cyc);
    e = sb.pop_front();
    n_vec++; if (port != e.port) begin n_miss++; $display("FAIL single_port: got %0d want %0d", port, e.port); end
    // First negedge after the grant edge is cycle 1, so ack at grant+NR+2 shows on negedge NR+3.
    n_vec++; if (cyc != NR + 3) begin n_miss++; $display("FAIL single_latency: got %0d want %0d", cyc, NR + 3); end
    n_vec++; if (c0 !== e.c) begin n_miss++; $display("FAIL single_c0: got %h want %h", c0, e.c); end
    n_vec++; if (c1 !== '0) begin n_miss++; $display("FAIL single_c1: got %h want 0", c1); end
    n_vec++; if (ack1 !== 1'b0) begin n_miss++; $display("FAIL single_ack1: got %b want 0", ack1); end
    $display("txn single port=%0d c0=%h cycles=%0d", port, c0, cyc);
    req0 = 1'b0;
    @(negedge clk);
    n_vec++; if (ack0 !== 1'b0) begin n_miss++; $display("FAIL single_ack0_drop: got %b want 0", ack0); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_contention();
    exp_t          e;
    int            port, cyc, n;
    logic [NB-1:0] got_c;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    // Tie from reset, then port 0 alone to move pri to 1, then another tie.
    for (int ph = 0; ph < 3; ph++) begin
      @(negedge clk);
      m0 = rnd(); k0 = rnd(); m1 = rnd(); k1 = rnd();
      if (ph == 2) begin
        sb.push_back('{1, enc(m1, k1)});
        sb.push_back('{0, enc(m0, k0)});
      end else begin
        sb.push_back('{0, enc(m0, k0)});
        if (ph == 0) sb.push_back('{1, enc(m1, k1)});
      end
      req0 = 1'b1;
      req1 = (ph != 1);
      n = (ph == 1) ? 1 : 2;
      for (int t = 0; t < n; t++) begin
        wait_ack(TMO + 8, port, cyc);
        e = sb.pop_front();
        got_c = (e.port == 0) ? c0 : c1;
        n_vec++; if (port != e.port) begin n_miss++; $display("FAIL contention_port ph%0d: got %0d want %0d", ph, port, e.port); end
        n_vec++; if (got_c !== e.c) begin n_miss++; $display("FAIL contention_c ph%0d: got %h want %h", ph, got_c, e.c); end
        n_vec++; if (((e.port == 0) ? ack1 : ack0) !== 1'b0) begin n_miss++; $display("FAIL contention_other_ack ph%0d: got 1 want 0", ph); end
        $display("txn contention ph=%0d port=%0d c=%h", ph, port, got_c);
        if (e.port == 0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);
        n_vec++; if (((e.port == 0) ? ack0 : ack1) !== 1'b0) begin n_miss++; $display("FAIL contention_ack_drop ph%0d: got 1 want 0", ph); end
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int   port, cyc;
    @(negedge clk);
    n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL timeout_err_before: got %b want 0", err); end
    core_hang = 1'b1;
    m0 = rnd(); k0 = rnd();
    req0 = 1'b1;
    sb.push_back('{0, '0});
    wait_ack(TMO + 8, port, cyc);
    e = sb.pop_front();
    n_vec++; if (port != e.port) begin n_miss++; $display("FAIL timeout_port: got %0d want %0d", port, e.port); end
    n_vec++; if (cyc != TMO + 2) begin n_miss++; $display("FAIL timeout_latency: got %0d want %0d", cyc, TMO + 2); end
    n_vec++; if (c0 !== e.c) begin n_miss++; $display("FAIL timeout_c0: got %h want %h", c0, e.c); end
    n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL timeout_err: got %b want 1", err); end
    $display("txn timeout port=%0d c0=%h err=%b", port, c0, err);
    req0 = 1'b0;
    core_hang = 1'b0;
    @(negedge clk);
    m1 = rnd(); k1 = rnd();
    req1 = 1'b1;
    sb.push_back('{1, enc(m1, k1)});
    wait_ack(TMO + 8, port, cyc);
    e = sb.pop_front();
    n_vec++; if (port != e.port) begin n_miss++; $display("FAIL timeout_next_port: got %0d want %0d", port, e.port); end
    n_vec++; if (c1 !== e.c) begin n_miss++; $display("FAIL timeout_next_c1: got %h want %h", c1, e.c); end
    n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL timeout_err_sticky: got %b want 1", err); end
    $display("txn after_timeout port=%0d c1=%h err=%b", port, c1, err);
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_input_change();
    exp_t          e;
    int            port, cyc;
    logic [NB-1:0] m_keep;
    logic [NK-1:0] k_keep;
    @(negedge clk);
    m_keep = rnd(); k_keep = rnd();
    m0 = m_keep; k0 = k_keep;
    req0 = 1'b1;
    sb.push_back('{0, enc(m_keep, k_keep)});
    repeat (2) @(negedge clk);
    m0 = ~m_keep; k0 = ~k_keep;
    for (int i = 0; i < TMO + 4 && core_req; i++) begin
      n_vec++; if (core_m !== m_keep) begin n_miss++; $display("FAIL input_change_core_m: got %h want %h", core_m, m_keep); end
      n_vec++; if (core_k !== k_keep) begin n_miss++; $display("FAIL input_change_core_k: got %h want %h", core_k, k_keep); end
      @(negedge clk);
    end
    wait_ack(TMO + 8, port, cyc);
    e = sb.pop_front();
    n_vec++; if (port != e.port) begin n_miss++; $display("FAIL input_change_port: got %0d want %0d", port, e.port); end
    n_vec++; if (c0 !== e.c) begin n_miss++; $display("FAIL input_change_c0: got %h want %h", c0, e.c); end
    $display("txn input_change port=%0d c0=%h", port, c0);
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int   port, cyc;
    @(negedge clk);
    m0 = rnd(); k0 = rnd();
    req0 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (core_req !== 1'b0) begin n_miss++; $display("FAIL midrst_core_req: got %b want 0", core_req); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_vec++; if (ack0 !== 1'b0) begin n_miss++; $display("FAIL midrst_ack0: got %b want 0", ack0); end
    n_vec++; if (c0 !== '0) begin n_miss++; $display("FAIL midrst_c0: got %h want 0", c0); end
    n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL midrst_err: got %b want 0", err); end
    $display("txn reset_mid_run aborted");
    rst = 1'b0;
    req0 = 1'b0;
    @(negedge clk);
    m0 = rnd(); k0 = rnd();
    req0 = 1'b1;
    sb.push_back('{0, enc(m0, k0)});
    wait_ack(TMO + 8, port, cyc);
    e = sb.pop_front();
    n_vec++; if (port != e.port) begin n_miss++; $display("FAIL midrst_fresh_port: got %0d want %0d", port, e.port); end
    n_vec++; if (cyc != NR + 3) begin n_miss++; $display("FAIL midrst_fresh_latency: got %0d want %0d", cyc, NR + 3); end
    n_vec++; if (c0 !== e.c) begin n_miss++; $display("FAIL midrst_fresh_c0: got %h want %h", c0, e.c); end
    $display("txn after_reset port=%0d c0=%h", port, c0);
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_early_drop();
    exp_t e;
    int   port, cyc;
    @(negedge clk);
    m1 = rnd(); k1 = rnd();
    req1 = 1'b1;
    sb.push_back('{1, enc(m1, k1)});
    repeat (2) @(negedge clk);
    req1 = 1'b0;
    wait_ack(TMO + 8, port, cyc);
    e = sb.pop_front();
    n_vec++; if (port != e.port) begin n_miss++; $display("FAIL early_drop_port: got %0d want %0d", port, e.port); end
    n_vec++; if (c1 !== e.c) begin n_miss++; $display("FAIL early_drop_c1: got %h want %h", c1, e.c); end
    @(negedge clk);
    n_vec++; if (ack1 !== 1'b0) begin n_miss++; $display("FAIL early_drop_pulse: got %b want 0", ack1); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL early_drop_idle: got %b want 0", busy); end
    $display("txn early_drop port=%0d c1=%h", port, c1);
  endtask

  task automatic test_back_to_back();
    exp_t          e;
    int            port, cyc;
    logic [NB-1:0] got_c;
    @(negedge clk);
    m0 = rnd(); k0 = rnd(); m1 = rnd(); k1 = rnd();
    sb.push_back('{0, enc(m0, k0)});
    sb.push_back('{1, enc(m1, k1)});
    req0 = 1'b1;
    req1 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_ack(TMO + 8, port, cyc);
      e = sb.pop_front();
      got_c = (e.port == 0) ? c0 : c1;
      n_vec++; if (port != (t % 2)) begin n_miss++; $display("FAIL b2b_port t%0d: got %0d want %0d", t, port, t % 2); end
      n_vec++; if (got_c !== e.c) begin n_miss++; $display("FAIL b2b_c t%0d: got %h want %h", t, got_c, e.c); end
      $display("txn b2b t=%0d port=%0d c=%h", t, port, got_c);
      if (e.port == 0) req0 = 1'b0; else req1 = 1'b0;
      @(negedge clk);
      if (t < 2) begin
        if (e.port == 0) begin
          m0 = rnd(); k0 = rnd(); req0 = 1'b1;
          sb.push_back('{0, enc(m0, k0)});
        end else begin
          m1 = rnd(); k1 = rnd(); req1 = 1'b1;
          sb.push_back('{1, enc(m1, k1)});
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_input_change();
    test_reset_mid_run();
    test_early_drop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
